// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus arbitration path.
// Holds the source count, the fixed source numbering used by the bus
// encoder, the arbiter state type and the encoder idle code.
package cpu_bus_pkg;

  localparam int NREQ_MAX = 24;

  localparam int R0     = 0;
  localparam int R1     = 1;
  localparam int R2     = 2;
  localparam int R3     = 3;
  localparam int R4     = 4;
  localparam int R5     = 5;
  localparam int R6     = 6;
  localparam int R7     = 7;
  localparam int R8     = 8;
  localparam int R9     = 9;
  localparam int R10    = 10;
  localparam int R11    = 11;
  localparam int R12    = 12;
  localparam int R13    = 13;
  localparam int R14    = 14;
  localparam int R15    = 15;
  localparam int HI     = 16;
  localparam int LO     = 17;
  localparam int ZHIGH  = 18;
  localparam int ZLOW   = 19;
  localparam int PC     = 20;
  localparam int MDR    = 21;
  localparam int INPORT = 22;
  localparam int CSIGN  = 23;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Encoder output when no grant bit is set.
  localparam logic [4:0] ENC_IDLE = 5'd31;

endpackage

// File: rtl/bus_grant_arbiter_rr_pick.sv
// Combinational round-robin pick.
// Ports:
//   req     - request vector, index = source number
//   ptr     - first source eligible to win (0..NREQ-1)
//   winner  - first set request at or after ptr, wrapping at NREQ-1
//   any_req - at least one request is set
// Method: rotate req down by ptr, find the lowest set bit, add ptr back.
module rr_pick
  import cpu_bus_pkg::*;
#(
  parameter int NREQ = NREQ_MAX
) (
  input  logic [NREQ-1:0] req,
  input  logic [4:0]      ptr,
  output logic [4:0]      winner,
  output logic            any_req
);

  localparam logic [5:0] NREQ6 = 6'(NREQ);

  logic [NREQ-1:0] rot;
  logic [4:0]      first;
  logic            found;
  logic [5:0]      sum;

  always_comb begin
    // Doubling the vector makes the right shift a rotation.
    rot   = NREQ'({req, req} >> ptr);
    first = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        first = 5'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, first};
    if (sum >= NREQ6) sum = sum - NREQ6;
    winner  = sum[4:0];
    any_req = |req;
  end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin arbiter for the shared CPU bus.
// Ports:
//   clock        - system clock, rising edge
//   clear_n      - asynchronous active-low reset
//   req          - level request per source
//   xfer_release - owner has finished; only looked at while a grant is held
//                  ("release" itself is a reserved word)
//   grant_onehot - registered one-hot source select, all-zero when idle
//   busy         - a grant is held
//   timeout      - one-cycle pulse in the IDLE cycle after a forced revoke
// Every grant is followed by at least one IDLE cycle, so the bus always
// turns around through the encoder idle code.
module bus_grant_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NREQ     = NREQ_MAX,
  parameter int HOLD_MAX = 64
) (
  input  logic            clock,
  input  logic            clear_n,
  input  logic [NREQ-1:0] req,
  input  logic            xfer_release,
  output logic [31:0]     grant_onehot,
  output logic            busy,
  output logic            timeout
);

  localparam logic [4:0] LAST      = 5'(NREQ - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  arb_state_t state;
  logic [4:0] ptr;
  logic [7:0] hold_cnt;
  logic [4:0] winner;
  logic       any_req;
  logic       owner_req;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Owner's request seen through the current grant mask.
  assign owner_req = |(grant_onehot & 32'(req));
  assign busy      = (state == GRANT);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state        <= IDLE;
      ptr          <= '0;
      hold_cnt     <= '0;
      grant_onehot <= '0;
      timeout      <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state        <= GRANT;
            grant_onehot <= 32'd1 << winner;
            ptr          <= (winner == LAST) ? 5'd0 : winner + 5'd1;
            hold_cnt     <= '0;
          end
        end
        GRANT: begin
          if (xfer_release || !owner_req) begin
            state        <= IDLE;
            grant_onehot <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state        <= IDLE;
            grant_onehot <= '0;
            timeout      <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state        <= IDLE;
          grant_onehot <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_grant_arbiter.sv
module tb_bus_grant_arbiter;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic [23:0] req = '0;
  logic        rel = 1'b0;
  logic [31:0] grant_onehot;
  logic        busy;
  logic        timeout;

  int n_checks = 0;
  int n_fails  = 0;

  bus_grant_arbiter #(.NREQ(24), .HOLD_MAX(4)) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .req          (req),
    .xfer_release (rel),
    .grant_onehot (grant_onehot),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] req;
    logic        rel;
    logic [31:0] grant;
    logic        busy;
    logic        tout;
  } vec_t;

  vec_t vt[15];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [31:0] g, input logic b, input logic t);
    check({name, ".grant"}, grant_onehot, g);
    check({name, ".busy"}, 32'(busy), 32'(b));
    check({name, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    // Round-robin over sources 3, 7, 20, then release in IDLE, owner drop,
    // release together with a new request.
    vt[0]  = '{24'h100088, 1'b0, 32'h0000_0008, 1'b1, 1'b0};
    vt[1]  = '{24'h100088, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vt[2]  = '{24'h100088, 1'b0, 32'h0000_0080, 1'b1, 1'b0};
    vt[3]  = '{24'h100088, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vt[4]  = '{24'h100088, 1'b0, 32'h0010_0000, 1'b1, 1'b0};
    vt[5]  = '{24'h100088, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vt[6]  = '{24'h100088, 1'b0, 32'h0000_0008, 1'b1, 1'b0};
    vt[7]  = '{24'h100088, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vt[8]  = '{24'h000000, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vt[9]  = '{24'h001000, 1'b0, 32'h0000_1000, 1'b1, 1'b0};
    vt[10] = '{24'h000000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vt[11] = '{24'h000020, 1'b0, 32'h0000_0020, 1'b1, 1'b0};
    vt[12] = '{24'h040020, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
    vt[13] = '{24'h040020, 1'b0, 32'h0004_0000, 1'b1, 1'b0};
    vt[14] = '{24'h040020, 1'b1, 32'h0000_0000, 1'b0, 1'b0};

    // Reset held with every source requesting.
    req = 24'hFFFFFF;
    tick();
    expect_out("reset_a", 32'h0, 1'b0, 1'b0);
    tick();
    expect_out("reset_b", 32'h0, 1'b0, 1'b0);
    #3 clear_n = 1'b1;
    tick();
    expect_out("first_grant", 32'h0000_0001, 1'b1, 1'b0);
    rel = 1'b1;
    req = '0;
    tick();
    expect_out("first_release", 32'h0, 1'b0, 1'b0);
    rel = 1'b0;

    foreach (vt[i]) begin
      req = vt[i].req;
      rel = vt[i].rel;
      tick();
      expect_out($sformatf("vec%0d", i), vt[i].grant, vt[i].busy, vt[i].tout);
    end

    // Forced revoke after 4 cycles; ptr is 19 so source 5 wins first.
    rel = 1'b0;
    req = 24'h000220;
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out($sformatf("hold_c%0d", c), 32'h0000_0020, 1'b1, 1'b0);
    end
    tick();
    expect_out("timeout_pulse", 32'h0, 1'b0, 1'b1);
    tick();
    expect_out("after_timeout", 32'h0000_0200, 1'b1, 1'b0);
    // Release on the limit cycle counts as a normal release.
    tick();
    tick();
    tick();
    expect_out("hold9_last", 32'h0000_0200, 1'b1, 1'b0);
    rel = 1'b1;
    tick();
    expect_out("rel_at_limit", 32'h0, 1'b0, 1'b0);
    rel = 1'b0;
    tick();
    expect_out("wrap_to_5", 32'h0000_0020, 1'b1, 1'b0);
    rel = 1'b1;
    req = '0;
    tick();
    expect_out("rel5", 32'h0, 1'b0, 1'b0);

    // Wrap-around through source 23.
    rel = 1'b0;
    req = 24'h400000;
    tick();
    expect_out("grant22", 32'h0040_0000, 1'b1, 1'b0);
    rel = 1'b1;
    tick();
    expect_out("rel22", 32'h0, 1'b0, 1'b0);
    rel = 1'b0;
    req = 24'h800001;
    tick();
    expect_out("grant23", 32'h0080_0000, 1'b1, 1'b0);
    rel = 1'b1;
    tick();
    expect_out("rel23", 32'h0, 1'b0, 1'b0);
    rel = 1'b0;
    tick();
    expect_out("grant0_wrap", 32'h0000_0001, 1'b1, 1'b0);
    rel = 1'b1;
    req = '0;
    tick();
    expect_out("rel0", 32'h0, 1'b0, 1'b0);

    // Async reset in the middle of a grant to source 9.
    rel = 1'b0;
    req = 24'h000200;
    tick();
    expect_out("grant9", 32'h0000_0200, 1'b1, 1'b0);
    #2 clear_n = 1'b0;
    #1;
    expect_out("async_clear", 32'h0, 1'b0, 1'b0);
    req = 24'h001200;
    #1 clear_n = 1'b1;
    tick();
    expect_out("ptr_restart", 32'h0000_0200, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bus_grant_arbiter.md
# bus_grant_arbiter

- Round-robin arbiter for the single shared CPU bus.
- Takes up to 24 request lines from bus sources and grants the bus to one source at a time.
- Drives the one-hot 32-bit source vector consumed by the 32-to-5 bus-select encoder.
- An all-zero grant leaves the encoder at its idle code (31), so no source drives the bus.

## Interface
Parameters:
- NREQ, 24, number of bus sources; legal range 1..24; grant bits NREQ..31 are tied 0.
- HOLD_MAX, 64, maximum cycles one grant may be held before forced revoke; legal range 2..255.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- clear_n  input  1  reset, asynchronous, active-low.
- req  input  NREQ  level request per source; index = source number.
- release  input  1  current owner finished its transfer; sampled only in GRANT.
- grant_onehot  output  32  one-hot bus source select to the encoder; all-zero when idle.
- busy  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is force-revoked.

## Operation
- States:
  - IDLE: grant_onehot = 0.
  - GRANT: exactly one grant_onehot bit set.
- IDLE:
  - If any req bit is set, pick the first set bit at or after ptr, scanning upward and wrapping at NREQ-1 to 0.
  - Register grant_onehot[winner] = 1 and go to GRANT.
  - Set ptr = winner+1, wrapping to 0 after NREQ-1.
  - Load hold_cnt = 0.
  - If no req bit is set, stay in IDLE with ptr unchanged.
- GRANT, checked in priority order:
  1. release = 1: go to IDLE and clear the grant.
  2. Owner's req bit = 0: treat as release; go to IDLE and clear the grant.
  3. hold_cnt = HOLD_MAX-1: go to IDLE, clear the grant, and pulse timeout for one cycle.
  4. Otherwise: hold_cnt += 1.
- Requests from non-owners in GRANT are ignored; they are re-evaluated on the next IDLE cycle.
- release asserted in IDLE is ignored.
- busy = (state == GRANT).
- ptr is a 5-bit register.
- hold_cnt is an 8-bit register; it saturates logically via the HOLD_MAX compare and never wraps.

## Timing
- Reset (clear_n low, asynchronous) sets:
  - state = IDLE, ptr = 0, hold_cnt = 0.
  - grant_onehot = 32'h0, busy = 0, timeout = 0.
- Leaving reset mid-grant: all outputs are already 0; arbitration resumes on the first edge after clear_n rises.
- Grant latency: req sampled high in IDLE at edge N gives grant_onehot valid after edge N (registered); no combinational path from req to grant_onehot.
- Revoke latency: release sampled at edge N gives grant_onehot = 0 after edge N.
- Bus turnaround: at least one all-zero cycle between consecutive grants, including back-to-back requests from the same source.
- Under continuous requests, the maximum grant length is HOLD_MAX cycles.
- timeout is high exactly in the first IDLE cycle following a forced revoke.
- Simultaneous events:
  - release and the HOLD_MAX limit in the same cycle: treat as a normal release; timeout = 0.
  - release together with new requests: new requests are arbitrated in the following IDLE cycle.
- Wrap-around: after a grant to source NREQ-1, ptr = 0.

## Structure
- Shared package cpu_bus_pkg holds:
  - NREQ_MAX = 24.
  - Source index constants: R0..R15 = 0..15, HI = 16, LO = 17, ZHIGH = 18, ZLOW = 19, PC = 20, MDR = 21, INPORT = 22, CSIGN = 23.
  - Arbiter state enum {IDLE, GRANT}.
  - ENC_IDLE = 5'd31.
- Sub-module rr_pick (combinational): inputs req[NREQ-1:0] and ptr[4:0]; outputs winner[4:0] and any_req.
  - Implemented as rotate, find-first-set, un-rotate.
- Registered state, counters and outputs live in bus_grant_arbiter.

## Test plan
- Reset: hold clear_n low with req = all-ones → grant_onehot = 0, busy = 0, timeout = 0; release clear_n → first grant is bit 0 (32'h00000001), one edge later.
- Round-robin: req bits 3, 7, 20 held high with release pulsed each grant → grants in order 3, 7, 20, 3, with one zero cycle between each.
- Wrap-around: ptr at 23, req bits 23 and 0 → grant 23 (32'h00800000), then 0 (32'h00000001).
- Timeout: HOLD_MAX = 4, req bit 5 held and release never asserted → grant 32'h00000020 for exactly 4 cycles, then 0 with a one-cycle timeout pulse; next grant goes to a different requester if one is present.
- Owner drop: grant to source 12, then req[12] deasserted without release → grant_onehot = 0 next cycle, timeout = 0.
- Async reset mid-grant: clear_n pulsed low between edges during a grant to source 9 → grant_onehot = 0 immediately, not waiting for a clock edge; ptr restarts at 0.
